// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path (driver and scan receiver).
package seg7_pkg;

    localparam int NUM_POS = 5;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_TEN   = 7'h3B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_TEN   = 4'hA;
    localparam logic [3:0] CODE_ERR   = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    function automatic logic is_one_hot(input logic [NUM_POS-1:0] v);
        return (v != {NUM_POS{1'b0}}) && ((v & (v - {{(NUM_POS-1){1'b0}}, 1'b1})) == {NUM_POS{1'b0}});
    endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// Maps a 7-bit segment pattern (dp excluded) back to its 4-bit digit code.
module seg7_pattern_decoder
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       illegal
);

    // Table lookup; anything not produced by the driver decodes to the error code.
    always_comb begin
        code    = CODE_ERR;
        illegal = 1'b1;
        case (pattern)
            SEG_0:     begin code = 4'h0;       illegal = 1'b0; end
            SEG_1:     begin code = 4'h1;       illegal = 1'b0; end
            SEG_2:     begin code = 4'h2;       illegal = 1'b0; end
            SEG_3:     begin code = 4'h3;       illegal = 1'b0; end
            SEG_4:     begin code = 4'h4;       illegal = 1'b0; end
            SEG_5:     begin code = 4'h5;       illegal = 1'b0; end
            SEG_6:     begin code = 4'h6;       illegal = 1'b0; end
            SEG_7:     begin code = 4'h7;       illegal = 1'b0; end
            SEG_8:     begin code = 4'h8;       illegal = 1'b0; end
            SEG_9:     begin code = 4'h9;       illegal = 1'b0; end
            SEG_TEN:   begin code = CODE_TEN;   illegal = 1'b0; end
            SEG_BLANK: begin code = CODE_BLANK; illegal = 1'b0; end
            default:   begin code = CODE_ERR;   illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Scan-bus receiver: synchronizes {sel,seg}, accepts each stable pair once and
// rebuilds the digit word with frame, error and stall reporting.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int         STABLE_CYCLES  = 4,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [4:0] FRAME_MASK     = 5'b01111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  sel_in,
    input  logic [7:0]  seg_in,
    input  logic        clear,
    output logic [19:0] digits_out,
    output logic [4:0]  digit_valid,
    output logic        frame_done,
    output logic        seg_error,
    output logic        sel_error,
    output logic        timeout
);

    localparam int BUS_W = NUM_POS + 8;
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [BUS_W-1:0] sync1_r, sync2_r, prev_r;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             accepted_r, acc_held_s, changed_s, fire_s;
    logic [4:0]       sel_s;
    logic             accept_s, sel_bad_s, frame_pend_s, to_hit_s;
    logic [3:0]       code_s;
    logic             illegal_s;
    logic [TO_W-1:0]  to_cnt_r, to_cnt_nxt_s;
    logic [19:0]      digits_r, digits_nxt_s;
    logic [4:0]       valid_r, valid_nxt_s, seen_r, seen_nxt_s;
    logic             frame_r, seg_err_r, sel_err_r, timeout_r;
    logic             frame_nxt_s, seg_err_nxt_s, sel_err_nxt_s, timeout_nxt_s;

    assign sel_s = sync2_r[BUS_W-1:8];

    seg7_pattern_decoder u_decoder (
        .pattern (sync2_r[6:0]),
        .code    (code_s),
        .illegal (illegal_s)
    );

    // cnt_s is the run length of the sampled pair minus one, including this cycle.
    always_comb begin
        changed_s = (sync2_r != prev_r);
        if (changed_s) begin
            cnt_s      = {CNT_W{1'b0}};
            acc_held_s = 1'b0;
        end else begin
            acc_held_s = accepted_r;
            if (cnt_r == CNT_MAX) begin
                cnt_s = CNT_MAX;
            end else begin
                cnt_s = cnt_r + CNT_W'(1);
            end
        end
        fire_s       = (cnt_s == CNT_MAX) && !acc_held_s;
        accept_s     = fire_s && is_one_hot(sel_s) && !clear;
        sel_bad_s    = fire_s && !is_one_hot(sel_s) && (sel_s != 5'd0) && !clear;
        frame_pend_s = ((seen_r & FRAME_MASK) == FRAME_MASK);
        to_hit_s     = !accept_s && (to_cnt_r == TO_LAST);
    end

    // Slot write for the accepted position.
    always_comb begin
        digits_nxt_s = digits_r;
        for (int i = 0; i < NUM_POS; i++) begin
            if (accept_s && sel_s[i]) begin
                digits_nxt_s[4*i +: 4] = code_s;
            end else begin
                digits_nxt_s[4*i +: 4] = digits_r[4*i +: 4];
            end
        end
    end

    // Flag, frame and stall bookkeeping; clear outranks timeout, timeout outranks frame.
    always_comb begin
        valid_nxt_s   = (clear || to_hit_s) ? 5'd0 : (valid_r | (accept_s ? sel_s : 5'd0));
        seen_nxt_s    = (clear || to_hit_s) ? 5'd0
                      : ((frame_pend_s ? 5'd0 : seen_r) | (accept_s ? sel_s : 5'd0));
        frame_nxt_s   = !clear && frame_pend_s && !to_hit_s;
        seg_err_nxt_s = clear ? 1'b0 : (seg_err_r | (accept_s && illegal_s));
        sel_err_nxt_s = clear ? 1'b0 : (sel_err_r | sel_bad_s);
        if (clear) begin
            timeout_nxt_s = 1'b0;
        end else if (to_hit_s) begin
            timeout_nxt_s = 1'b1;
        end else if (accept_s) begin
            timeout_nxt_s = 1'b0;
        end else begin
            timeout_nxt_s = timeout_r;
        end
        if (accept_s) begin
            to_cnt_nxt_s = {TO_W{1'b0}};
        end else if (to_cnt_r == TO_MAX) begin
            to_cnt_nxt_s = TO_MAX;
        end else begin
            to_cnt_nxt_s = to_cnt_r + TO_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r    <= {BUS_W{1'b0}};
            sync2_r    <= {BUS_W{1'b0}};
            prev_r     <= {BUS_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            accepted_r <= 1'b0;
            to_cnt_r   <= {TO_W{1'b0}};
            digits_r   <= 20'hFFFFF;
            valid_r    <= 5'd0;
            seen_r     <= 5'd0;
            frame_r    <= 1'b0;
            seg_err_r  <= 1'b0;
            sel_err_r  <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            sync1_r    <= {sel_in, seg_in};
            sync2_r    <= sync1_r;
            prev_r     <= sync2_r;
            cnt_r      <= cnt_s;
            accepted_r <= acc_held_s | fire_s;
            to_cnt_r   <= to_cnt_nxt_s;
            digits_r   <= digits_nxt_s;
            valid_r    <= valid_nxt_s;
            seen_r     <= seen_nxt_s;
            frame_r    <= frame_nxt_s;
            seg_err_r  <= seg_err_nxt_s;
            sel_err_r  <= sel_err_nxt_s;
            timeout_r  <= timeout_nxt_s;
        end
    end

    assign digits_out  = digits_r;
    assign digit_valid = valid_r;
    assign frame_done  = frame_r;
    assign seg_error   = seg_err_r;
    assign sel_error   = sel_err_r;
    assign timeout     = timeout_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed test-plan sequences plus random scans,
// every cycle compared against an input-history reference model.
module tb_seg7_scan_decoder;

    localparam int         S    = 4;
    localparam int         T    = 4096;
    localparam logic [4:0] MASK = 5'b01111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  sel_in = 5'd0;
    logic [7:0]  seg_in = 8'd0;
    logic        clear = 1'b0;
    logic [19:0] digits_out;
    logic [4:0]  digit_valid;
    logic        frame_done, seg_error, sel_error, timeout;

    int checks = 0;
    int failures = 0;
    int frame_cnt = 0;

    seg7_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T), .FRAME_MASK(MASK)) dut (
        .clk(clk), .reset(reset), .sel_in(sel_in), .seg_in(seg_in), .clear(clear),
        .digits_out(digits_out), .digit_valid(digit_valid), .frame_done(frame_done),
        .seg_error(seg_error), .sel_error(sel_error), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: acceptance is derived from the raw input history.
    logic [12:0] hist[$];
    logic [19:0] m_digits;
    logic [4:0]  m_valid, m_seen;
    logic        m_frame, m_seg_err, m_sel_err, m_timeout;
    int          m_to_cnt;
    logic [6:0]  digit_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [6:0]  pool [12] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h3B, 7'h00};

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [3:0] ref_decode(input logic [6:0] p, output logic bad);
        bad = 1'b0;
        for (int d = 0; d < 10; d++) begin
            if (p == digit_tab[d]) return 4'(d);
        end
        if (p == 7'h3B) return 4'hA;
        if (p == 7'h00) return 4'hF;
        bad = 1'b1;
        return 4'hE;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < S + 3; k++) hist.push_front(13'h0);
        m_digits = 20'hFFFFF; m_valid = 5'd0; m_seen = 5'd0;
        m_frame = 1'b0; m_seg_err = 1'b0; m_sel_err = 1'b0; m_timeout = 1'b0;
        m_to_cnt = 0;
    endtask

    task automatic model_edge(input logic [4:0] s, input logic [7:0] g, input logic c);
        logic [12:0] cand;
        logic        fire, acc, multi, pend, hit, bad;
        logic [3:0]  code;
        logic [4:0]  csel;
        hist.push_front({s, g});
        if (hist.size() > S + 3) void'(hist.pop_back());
        cand = hist[2];
        fire = 1'b1;
        for (int k = 2; k <= S + 1; k++) if (hist[k] != cand) fire = 1'b0;
        if (hist[S + 2] == cand) fire = 1'b0;
        csel  = cand[12:8];
        acc   = fire && !c && ($countones(csel) == 1);
        multi = fire && !c && ($countones(csel) > 1);
        pend  = ((m_seen & MASK) == MASK);
        hit   = !acc && (m_to_cnt == T - 1);
        code  = ref_decode(cand[6:0], bad);
        if (c) begin
            m_seg_err = 1'b0; m_sel_err = 1'b0; m_valid = 5'd0; m_seen = 5'd0;
            m_timeout = 1'b0; m_frame = 1'b0;
        end else begin
            m_frame = pend && !hit;
            if (pend) m_seen = 5'd0;
            if (acc) begin
                for (int i = 0; i < 5; i++) if (csel[i]) m_digits[4*i +: 4] = code;
                m_valid = m_valid | csel;
                m_seen  = m_seen | csel;
                m_timeout = 1'b0;
                if (bad) m_seg_err = 1'b1;
            end
            if (multi) m_sel_err = 1'b1;
            if (hit) begin
                m_timeout = 1'b1; m_valid = 5'd0; m_seen = 5'd0;
            end
        end
        m_to_cnt = acc ? 0 : ((m_to_cnt < T) ? m_to_cnt + 1 : T);
    endtask

    task automatic cycle(input logic [4:0] s, input logic [7:0] g, input logic c);
        sel_in = s; seg_in = g; clear = c;
        @(posedge clk);
        model_edge(s, g, c);
        #1;
        if (frame_done === 1'b1) frame_cnt++;
        check_eq("outputs",
                 {3'b000, digits_out, digit_valid, frame_done, seg_error, sel_error, timeout},
                 {3'b000, m_digits, m_valid, m_frame, m_seg_err, m_sel_err, m_timeout});
    endtask

    task automatic hold(input logic [4:0] s, input logic [7:0] g, input int n);
        for (int k = 0; k < n; k++) cycle(s, g, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_digits"}, {12'h0, digits_out}, 32'h000FFFFF);
        check_eq({tag, "_valid"}, {27'h0, digit_valid}, 32'h0);
        check_eq({tag, "_flags"}, {28'h0, frame_done, seg_error, sel_error, timeout}, 32'h0);
    endtask

    initial begin
        int lat;
        logic [4:0] s;
        logic [7:0] g;
        int kind, b1, b2, len;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        reset = 1'b0;
        model_reset();

        // Full frame 3,2,1,0
        frame_cnt = 0;
        hold(5'b01000, 8'h66, 10);
        hold(5'b00100, 8'h00, 10);
        hold(5'b00010, 8'h00, 10);
        hold(5'b00001, 8'h4F, 10);
        hold(5'b00000, 8'h00, 4);
        check_eq("frame_digits", {16'h0, digits_out[15:0]}, 32'h4FF3);
        check_eq("frame_valid", {27'h0, digit_valid}, 32'h0F);
        check_eq("frame_pulses", frame_cnt, 32'd1);
        check_eq("frame_errors", {30'h0, seg_error, sel_error}, 32'h0);

        // Short hold is ignored; a full hold lands STABLE_CYCLES+2 edges after the change
        hold(5'b00100, 8'h06, 3);
        hold(5'b00000, 8'h00, 3);
        check_eq("short_hold", {28'h0, digits_out[11:8]}, 32'hF);
        lat = -1;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) cycle(5'b00100, 8'h06, 1'b0);
            else       cycle(5'b00000, 8'h00, 1'b0);
            if (lat < 0 && digits_out[11:8] == 4'h1) lat = k;
        end
        check_eq("latency", lat, 32'd5);

        // Illegal pattern, then a legal one; seg_error sticks until clear
        hold(5'b00001, 8'h55, 6);
        hold(5'b00000, 8'h00, 2);
        check_eq("illegal_slot", {28'h0, digits_out[3:0]}, 32'hE);
        check_eq("seg_err_set", {31'h0, seg_error}, 32'h1);
        hold(5'b00001, 8'h06, 6);
        hold(5'b00000, 8'h00, 2);
        check_eq("legal_slot", {28'h0, digits_out[3:0]}, 32'h1);
        check_eq("seg_err_sticky", {31'h0, seg_error}, 32'h1);
        cycle(5'b00000, 8'h00, 1'b1);
        check_eq("clear_flags", {26'h0, digit_valid, seg_error}, 32'h0);

        // Multi-hot select, then stall
        hold(5'b00010, 8'h7D, 6);
        hold(5'b01000 | 5'b00000, 8'h00, 0);
        hold(5'b00011, 8'h3F, 8);
        hold(5'b00000, 8'h00, 2);
        check_eq("sel_err_set", {31'h0, sel_error}, 32'h1);
        check_eq("multi_digits", {12'h0, digits_out}, 32'hF4161);
        hold(5'b00000, 8'h00, T + 4);
        check_eq("timeout_set", {26'h0, timeout, digit_valid}, 32'h20);
        hold(5'b00010, 8'h7F, 6);
        check_eq("timeout_clr", {31'h0, timeout}, 32'h0);
        check_eq("post_to_digits", {12'h0, digits_out}, 32'hF4181);
        check_eq("post_to_valid", {27'h0, digit_valid}, 32'h02);

        // Clear on the acceptance edge of position 2
        hold(5'b00000, 8'h00, 2);
        for (int k = 0; k < 8; k++) cycle(5'b00100, 8'h07, (k == 5));
        hold(5'b00000, 8'h00, 2);
        check_eq("clear_drop_slot", {28'h0, digits_out[11:8]}, 32'h1);
        check_eq("clear_drop_flags", {25'h0, sel_error, timeout, digit_valid}, 32'h0);

        // Reset mid-frame, then a fresh frame
        hold(5'b00001, 8'h6D, 6);
        hold(5'b00010, 8'h5B, 6);
        reset = 1'b1; sel_in = 5'd0; seg_in = 8'd0; clear = 1'b0;
        #2;
        check_reset_values("mid_rst");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        frame_cnt = 0;
        hold(5'b00001, 8'h3F, 8);
        hold(5'b00010, 8'h06, 8);
        hold(5'b00100, 8'h5B, 8);
        check_eq("partial_frame", frame_cnt, 32'd0);
        hold(5'b01000, 8'h3B, 8);
        hold(5'b00000, 8'h00, 3);
        check_eq("fresh_frame", frame_cnt, 32'd1);
        check_eq("fresh_digits", {12'h0, digits_out}, 32'hFA210);

        // Random scans
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom % 16);
            len  = int'($urandom_range(1, 7));
            if (kind == 0) begin
                b1 = int'($urandom % 5);
                b2 = (b1 + 1 + int'($urandom % 4)) % 5;
                s = (5'b00001 << b1) | (5'b00001 << b2);
            end else if (kind == 1) begin
                s = 5'd0;
            end else begin
                s = 5'b00001 << ($urandom % 5);
            end
            if ($urandom % 4 == 0) g = 8'($urandom);
            else g = {1'($urandom), pool[$urandom % 12]};
            for (int k = 0; k < len; k++) cycle(s, g, ($urandom % 40 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
